// File: rtl/pipeline_pkg.sv
// Shared pipeline types: operand-select encodings, register-address type, datapath widths.
package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    A_SEL_RS1 = 1'b0,
    A_SEL_PC  = 1'b1
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

endpackage

// File: rtl/operand_fwd.sv
// Resolves one source operand against the EX/WB result buses and flags a stall.
// Macro FORWARDING_EN: forward EX/WB results; otherwise stall on any pending writer.
module operand_fwd
  import pipeline_pkg::*;
(
  input  logic                  i_used,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [XLEN-1:0]       i_rs_data,
  input  logic                  i_ex_wen,
  input  logic [REG_ADDR_W-1:0] i_ex_addr,
  input  logic [XLEN-1:0]       i_ex_data,
  input  logic                  i_ex_busy,
  input  logic                  i_wb_wen,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_data,
  output logic                  o_hazard
);

  logic w_nz;
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_nz     = |i_rs_addr;
  assign w_ex_hit = i_ex_wen && (i_ex_addr == i_rs_addr) && w_nz;
  assign w_wb_hit = i_wb_wen && (i_wb_addr == i_rs_addr) && w_nz;

`ifdef FORWARDING_EN
  // The youngest writer (EX) wins over WB.
  always_comb begin
    o_data = i_rs_data;
    if (!w_nz)         o_data = '0;
    else if (w_ex_hit) o_data = i_ex_data;
    else if (w_wb_hit) o_data = i_wb_data;
  end

  assign o_hazard = i_used && w_ex_hit && i_ex_busy;
`else
  logic w_unused;
  assign w_unused = ^{i_ex_data, i_wb_data, i_ex_busy};

  assign o_data   = w_nz ? i_rs_data : '0;
  assign o_hazard = i_used && (w_ex_hit || w_wb_hit);
`endif

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: resolves operands, applies a/b muxing and holds the ALU payload.
// Macro FORWARDING_EN selects EX/WB forwarding; default build stalls on pending writers.
module id_ex_reg
  import pipeline_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [ALU_OP_W-1:0]   i_alu_op,
  input  logic                  i_a_sel,
  input  logic                  i_b_sel,
  input  logic [XLEN-1:0]       i_imm,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_wen,
  input  logic                  i_ex_wen,
  input  logic [REG_ADDR_W-1:0] i_ex_addr,
  input  logic [XLEN-1:0]       i_ex_data,
  input  logic                  i_ex_busy,
  input  logic                  i_wb_wen,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ALU_OP_W-1:0]   o_alu_op,
  output logic [XLEN-1:0]       o_alu_a,
  output logic [XLEN-1:0]       o_alu_b,
  output logic [XLEN-1:0]       o_pc,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_rd_wen
);

  logic                  r_valid;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic [XLEN-1:0]       r_alu_a;
  logic [XLEN-1:0]       r_alu_b;
  logic [XLEN-1:0]       r_pc;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_wen;

  logic            w_rs1_used;
  logic            w_rs2_used;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rs1_hz;
  logic            w_rs2_hz;
  logic            w_hazard;
  logic            w_accept;

  assign w_rs1_used = (a_sel_e'(i_a_sel) == A_SEL_RS1);
  assign w_rs2_used = (b_sel_e'(i_b_sel) == B_SEL_RS2);

  operand_fwd u_fwd_rs1 (
    .i_used    (w_rs1_used),
    .i_rs_addr (i_rs1_addr),
    .i_rs_data (i_rs1_data),
    .i_ex_wen  (i_ex_wen),
    .i_ex_addr (i_ex_addr),
    .i_ex_data (i_ex_data),
    .i_ex_busy (i_ex_busy),
    .i_wb_wen  (i_wb_wen),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .o_data    (w_rs1_val),
    .o_hazard  (w_rs1_hz)
  );

  operand_fwd u_fwd_rs2 (
    .i_used    (w_rs2_used),
    .i_rs_addr (i_rs2_addr),
    .i_rs_data (i_rs2_data),
    .i_ex_wen  (i_ex_wen),
    .i_ex_addr (i_ex_addr),
    .i_ex_data (i_ex_data),
    .i_ex_busy (i_ex_busy),
    .i_wb_wen  (i_wb_wen),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .o_data    (w_rs2_val),
    .o_hazard  (w_rs2_hz)
  );

  assign w_hazard = i_valid && (w_rs1_hz || w_rs2_hz);
  assign o_ready  = (!r_valid || i_ready) && !w_hazard && !i_flush;
  assign w_accept = i_valid && o_ready;

  // Flush only kills the valid bit; the payload is left as it was.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_pc      <= '0;
      r_rd_addr <= '0;
      r_rd_wen  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_alu_op  <= i_alu_op;
      r_alu_a   <= w_rs1_used ? w_rs1_val : i_pc;
      r_alu_b   <= w_rs2_used ? w_rs2_val : i_imm;
      r_pc      <= i_pc;
      r_rd_addr <= i_rd_addr;
      r_rd_wen  <= i_rd_wen;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_alu_op  = r_alu_op;
  assign o_alu_a   = r_alu_a;
  assign o_alu_b   = r_alu_b;
  assign o_pc      = r_pc;
  assign o_rd_addr = r_rd_addr;
  assign o_rd_wen  = r_rd_wen;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg; covers both FORWARDING_EN builds.
module tb_id_ex_reg;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [3:0]  i_alu_op;
  logic        i_a_sel;
  logic        i_b_sel;
  logic [31:0] i_imm;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wen;
  logic        i_ex_wen;
  logic [4:0]  i_ex_addr;
  logic [31:0] i_ex_data;
  logic        i_ex_busy;
  logic        i_wb_wen;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_alu_op;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [31:0] o_pc;
  logic [4:0]  o_rd_addr;
  logic        o_rd_wen;

  int total  = 0;
  int passed = 0;

  id_ex_reg dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_alu_op(i_alu_op), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel),
    .i_imm(i_imm), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_rd_wen(i_rd_wen), .i_ex_wen(i_ex_wen), .i_ex_addr(i_ex_addr),
    .i_ex_data(i_ex_data), .i_ex_busy(i_ex_busy), .i_wb_wen(i_wb_wen),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_op(o_alu_op),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_pc(o_pc),
    .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [3:0] op, input logic asel,
                       input logic bsel, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd);
    i_valid = 1'b1; i_pc = pc; i_alu_op = op; i_a_sel = asel; i_b_sel = bsel;
    i_imm = imm; i_rs1_addr = rs1; i_rs1_data = d1; i_rs2_addr = rs2;
    i_rs2_data = d2; i_rd_addr = rd; i_rd_wen = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 0; i_pc = 0; i_alu_op = 0; i_a_sel = 0; i_b_sel = 0;
    i_imm = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_data = 0; i_rs2_data = 0;
    i_rd_addr = 0; i_rd_wen = 0; i_ex_wen = 0; i_ex_addr = 0; i_ex_data = 0;
    i_ex_busy = 0; i_wb_wen = 0; i_wb_addr = 0; i_wb_data = 0; i_flush = 0;
    i_ready = 1'b1;
    #2;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_alu_a", o_alu_a, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(o_ready), 32'h1);

    // ADD x1 = x5 + x6
    instr(32'h0000_1000, 4'h0, 1'b0, 1'b0, 32'h0, 5'd5, 32'h10, 5'd6, 32'h20, 5'd1);
    step();
    check("add_valid", 32'(o_valid), 32'h1);
    check("add_a", o_alu_a, 32'h10);
    check("add_b", o_alu_b, 32'h20);
    check("add_op", 32'(o_alu_op), 32'h0);
    check("add_pc", o_pc, 32'h0000_1000);
    check("add_rd", 32'(o_rd_addr), 32'd1);

    // back-to-back: pc/imm selects, SUB opcode
    instr(32'h0000_0100, 4'h8, 1'b1, 1'b1, 32'h44, 5'd5, 32'h10, 5'd6, 32'h20, 5'd2);
    step();
    check("sel_a_pc", o_alu_a, 32'h100);
    check("sel_b_imm", o_alu_b, 32'h44);
    check("sel_op", 32'(o_alu_op), 32'h8);

    // x0 always reads zero
    instr(32'h0000_0104, 4'h0, 1'b0, 1'b1, 32'h3, 5'd0, 32'h77, 5'd0, 32'h0, 5'd3);
    step();
    check("x0_a", o_alu_a, 32'h0);

`ifdef FORWARDING_EN
    instr(32'h200, 4'h0, 1'b0, 1'b1, 32'h0, 5'd5, 32'h11, 5'd0, 32'h0, 5'd4);
    i_ex_wen = 1; i_ex_addr = 5'd5; i_ex_data = 32'hAA;
    i_wb_wen = 1; i_wb_addr = 5'd5; i_wb_data = 32'hBB;
    #1;
    check("fwd_ready", 32'(o_ready), 32'h1);
    step();
    check("fwd_ex_prio", o_alu_a, 32'hAA);
    i_ex_wen = 0;
    step();
    check("fwd_wb", o_alu_a, 32'hBB);
    i_wb_wen = 0;
    i_rs1_addr = 5'd0; i_ex_wen = 1; i_ex_addr = 5'd0; i_ex_data = 32'h55;
    step();
    check("fwd_x0", o_alu_a, 32'h0);
    i_rs1_addr = 5'd7; i_ex_addr = 5'd7; i_ex_data = 32'h70; i_ex_busy = 1;
    #1;
    check("busy_ready0", 32'(o_ready), 32'h0);
    step();
    check("busy_drain", 32'(o_valid), 32'h0);
    check("busy_ready1", 32'(o_ready), 32'h0);
    i_ex_busy = 0;
    #1;
    check("busy_release", 32'(o_ready), 32'h1);
    step();
    check("busy_fwd_a", o_alu_a, 32'h70);
    i_ex_wen = 0;
`else
    instr(32'h200, 4'h0, 1'b0, 1'b1, 32'h0, 5'd9, 32'h99, 5'd0, 32'h0, 5'd4);
    i_wb_wen = 1; i_wb_addr = 5'd9; i_wb_data = 32'hBB;
    #1;
    check("wb_hz_ready", 32'(o_ready), 32'h0);
    step();
    check("wb_hz_drain", 32'(o_valid), 32'h0);
    check("wb_hz_hold", 32'(o_ready), 32'h0);
    i_wb_wen = 0;
    #1;
    check("wb_release", 32'(o_ready), 32'h1);
    step();
    check("nofwd_a", o_alu_a, 32'h99);
    i_ex_wen = 1; i_ex_addr = 5'd9; i_ex_data = 32'hCC; i_ex_busy = 0;
    #1;
    check("ex_hz_nobusy", 32'(o_ready), 32'h0);
    i_a_sel = 1'b1;
    #1;
    check("unused_src_ok", 32'(o_ready), 32'h1);
    i_ex_wen = 0;
`endif

    // downstream stall
    instr(32'h300, 4'h2, 1'b0, 1'b0, 32'h0, 5'd10, 32'h1234, 5'd11, 32'h5678, 5'd12);
    step();
    check("stall_load_a", o_alu_a, 32'h1234);
    i_ready = 0;
    instr(32'h304, 4'h3, 1'b0, 1'b0, 32'h0, 5'd13, 32'hDEAD, 5'd14, 32'hBEEF, 5'd15);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", 32'(o_ready), 32'h0);
      step();
      check("stall_a", o_alu_a, 32'h1234);
      check("stall_valid", 32'(o_valid), 32'h1);
    end
    i_ready = 1;
    #1;
    check("unstall_ready", 32'(o_ready), 32'h1);
    step();
    check("unstall_a", o_alu_a, 32'hDEAD);
    check("unstall_b", o_alu_b, 32'hBEEF);

    // flush beats accept; payload stays
    instr(32'h308, 4'h1, 1'b0, 1'b0, 32'h0, 5'd1, 32'h4444, 5'd2, 32'h5555, 5'd3);
    i_flush = 1;
    #1;
    check("flush_ready", 32'(o_ready), 32'h0);
    step();
    check("flush_valid", 32'(o_valid), 32'h0);
    check("flush_payload", o_alu_a, 32'hDEAD);
    i_flush = 0;

    // async reset mid-stall
    step();
    check("pre_rst_valid", 32'(o_valid), 32'h1);
    i_ready = 0;
    i_valid = 0;
    step();
    #2;
    i_rst = 1;
    #1;
    check("arst_valid", 32'(o_valid), 32'h0);
    check("arst_a", o_alu_a, 32'h0);
    check("arst_b", o_alu_b, 32'h0);
    check("arst_pc", o_pc, 32'h0);
    check("arst_op", 32'(o_alu_op), 32'h0);
    check("arst_rd", {26'h0, o_rd_wen, o_rd_addr}, 32'h0);
    @(negedge i_clk);
    i_rst = 0;
    i_ready = 1;
    #1;
    check("arst_ready", 32'(o_ready), 32'h1);
    step();
    check("arst_idle", 32'(o_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
